accel_hub: RTL and testbench
============================

ACCEL_HUB -- requirements
Module: accel_hub

Interface
REQ-001 SHALL have parameter ACCEL_COUNT, default 4, number of attached accelerators (1..16), served as ids 0..ACCEL_COUNT-1.
REQ-002 SHALL have parameter REG_WIDTH, default 16, data width of all data ports.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, entries per FIFO (power of two, >=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 accel_id  input  4  CPU-selected accelerator id.
REQ-007 accel_can_write  output  1  selected accelerator's input FIFO not full.
REQ-008 accel_can_read  output  1  selected accelerator's result FIFO not empty.
REQ-009 accel_write_enable  input  1  CPU pushes accel_write_data to selected accelerator.
REQ-010 accel_write_data  input  REG_WIDTH  operand word from CPU.
REQ-011 accel_read_enable  input  1  CPU pops selected result FIFO head.
REQ-012 accel_read_data  output  REG_WIDTH  head of selected result FIFO.
REQ-013 acc_in_valid  output  ACCEL_COUNT  per-accelerator operand valid.
REQ-014 acc_in_ready  input  ACCEL_COUNT  per-accelerator operand ready.
REQ-015 acc_in_data  output  ACCEL_COUNT*REG_WIDTH  per-accelerator operand, slice i = accelerator i.
REQ-016 acc_out_valid  input  ACCEL_COUNT  per-accelerator result valid.
REQ-017 acc_out_ready  output  ACCEL_COUNT  per-accelerator result ready.
REQ-018 acc_out_data  input  ACCEL_COUNT*REG_WIDTH  per-accelerator result, slice i.
REQ-019 err  output  1  sticky protocol-violation flag.

Function
REQ-020 Each accelerator i SHALL own one input FIFO and one result FIFO, FIFO_DEPTH entries each, registered storage, no fall-through.
REQ-021 accel_can_write, accel_can_read, accel_read_data SHALL be combinational from accel_id and FIFO state (same-cycle, as the CPU stalls on them combinationally).
REQ-022 For accel_id >= ACCEL_COUNT: accel_can_write=0, accel_can_read=0, accel_read_data=0.
REQ-023 Push to input FIFO[accel_id] SHALL occur at the clock edge where accel_write_enable=1 and accel_can_write=1; entry visible on acc_in_valid[i] the following cycle.
REQ-024 acc_in_valid[i] = input FIFO i not empty; acc_in_data slice i = its head; pop on acc_in_valid[i] & acc_in_ready[i].
REQ-025 acc_out_ready[i] = result FIFO i not full; push on acc_out_valid[i] & acc_out_ready[i]; head visible on accel_read_data the following cycle.
REQ-026 Pop of result FIFO[accel_id] SHALL occur at the edge where accel_read_enable=1 and accel_can_read=1.
REQ-027 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy unchanged; order preserved.
REQ-028 Full FIFO: can_write/ready deasserted, no overwrite; a same-cycle pop does not re-enable push that cycle.
REQ-029 Empty FIFO: valid/can_read deasserted, head value don't-care internally but accel_read_data forced 0 when can_read=0.
REQ-030 Occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
REQ-031 Each FIFO SHALL be strictly FIFO per accelerator; no reordering; accelerators independent.
REQ-032 err SHALL set at the edge of write_enable with can_write=0, or read_enable with can_read=0 (incl. out-of-range id); ignored access changes no FIFO; err holds until reset.

Reset
REQ-033 rst=1 SHALL asynchronously clear all pointers, counters and err: acc_in_valid=0, acc_out_ready=all 1, accel_can_read=0, accel_can_write=1 (id in range), accel_read_data=0, err=0.
REQ-034 Reset mid-transfer SHALL discard all buffered words; first post-reset push lands at pointer 0.

Verification
REQ-035 id=1, write 0x1234 with acc_in_ready[1]=0 -> cycle+1 acc_in_valid[1]=1, slice1=0x1234; others 0; can_write stays 1.
REQ-036 id=2, three writes 0xA,0xB,0xC, acc_in_ready[2]=0 -> after two, can_write=0; third ignored, err=1; ready[2]=1 yields 0xA then 0xB.
REQ-037 acc_out_valid[3]=1 data 0x55AA for one cycle, id=3 -> next cycle can_read=1, read_data=0x55AA; read_enable -> can_read=0, read_data=0.
REQ-038 Result FIFO 0 holding one word, same-cycle read pop and acc_out push 0x0042 -> occupancy stays 1, read_data=0x0042 next cycle.
REQ-039 id=7 with ACCEL_COUNT=4, write_enable=1 -> can_write=0, no acc_in_valid change, err=1.
REQ-040 Two words buffered, rst pulsed asynchronously between edges -> outputs immediately at REQ-033 values; buffered words never appear.

Source files
------------

// File: rtl/accel_hub.sv
// accel_hub: CPU-facing hub with one input FIFO and one result FIFO per
// attached accelerator, plus a sticky flag for ignored CPU accesses.
module accel_hub #(
  parameter int unsigned ACCEL_COUNT = 4,
  parameter int unsigned REG_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       accel_id,
  output logic                             accel_can_write,
  output logic                             accel_can_read,
  input  logic                             accel_write_enable,
  input  logic [REG_WIDTH-1:0]             accel_write_data,
  input  logic                             accel_read_enable,
  output logic [REG_WIDTH-1:0]             accel_read_data,
  output logic [ACCEL_COUNT-1:0]           acc_in_valid,
  input  logic [ACCEL_COUNT-1:0]           acc_in_ready,
  output logic [ACCEL_COUNT*REG_WIDTH-1:0] acc_in_data,
  input  logic [ACCEL_COUNT-1:0]           acc_out_valid,
  output logic [ACCEL_COUNT-1:0]           acc_out_ready,
  input  logic [ACCEL_COUNT*REG_WIDTH-1:0] acc_out_data,
  output logic                             err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ID_W  = 4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [REG_WIDTH-1:0] in_mem_q  [ACCEL_COUNT][FIFO_DEPTH];
  logic [REG_WIDTH-1:0] in_mem_d  [ACCEL_COUNT][FIFO_DEPTH];
  logic [REG_WIDTH-1:0] out_mem_q [ACCEL_COUNT][FIFO_DEPTH];
  logic [REG_WIDTH-1:0] out_mem_d [ACCEL_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]     in_wr_q  [ACCEL_COUNT], in_wr_d  [ACCEL_COUNT];
  logic [PTR_W-1:0]     in_rd_q  [ACCEL_COUNT], in_rd_d  [ACCEL_COUNT];
  logic [CNT_W-1:0]     in_cnt_q [ACCEL_COUNT], in_cnt_d [ACCEL_COUNT];
  logic [PTR_W-1:0]     out_wr_q  [ACCEL_COUNT], out_wr_d  [ACCEL_COUNT];
  logic [PTR_W-1:0]     out_rd_q  [ACCEL_COUNT], out_rd_d  [ACCEL_COUNT];
  logic [CNT_W-1:0]     out_cnt_q [ACCEL_COUNT], out_cnt_d [ACCEL_COUNT];
  logic                 err_q, err_d;

  logic [ACCEL_COUNT-1:0] in_full_c, out_empty_c;
  logic [ACCEL_COUNT-1:0] in_push_c, in_pop_c, out_push_c, out_pop_c;
  logic                   sel_can_write_c, sel_can_read_c;
  logic [REG_WIDTH-1:0]   sel_head_c;

  // Per-accelerator FIFO status and accelerator-side handshake outputs.
  always_comb begin
    in_full_c     = '0;
    out_empty_c   = '0;
    acc_in_valid  = '0;
    acc_out_ready = '0;
    acc_in_data   = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      in_full_c[i]   = (in_cnt_q[i] == FULL_CNT);
      out_empty_c[i] = (out_cnt_q[i] == '0);
      acc_in_valid[i]  = (in_cnt_q[i] != '0);
      acc_out_ready[i] = (out_cnt_q[i] != FULL_CNT);
      acc_in_data[i*REG_WIDTH +: REG_WIDTH] = in_mem_q[i][in_rd_q[i]];
    end
  end

  // CPU-side view of the selected accelerator; out-of-range ids match nothing.
  always_comb begin
    sel_can_write_c = 1'b0;
    sel_can_read_c  = 1'b0;
    sel_head_c      = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      if (accel_id == ID_W'(i)) begin
        sel_can_write_c = !in_full_c[i];
        sel_can_read_c  = !out_empty_c[i];
        sel_head_c      = out_mem_q[i][out_rd_q[i]];
      end
    end
  end

  assign accel_can_write = sel_can_write_c;
  assign accel_can_read  = sel_can_read_c;
  assign accel_read_data = sel_can_read_c ? sel_head_c : '0;
  assign err             = err_q;

  // Push/pop strobes for every FIFO, all qualified by pre-edge state.
  always_comb begin
    in_push_c  = '0;
    in_pop_c   = '0;
    out_push_c = '0;
    out_pop_c  = '0;
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      in_push_c[i]  = accel_write_enable && accel_can_write && (accel_id == ID_W'(i));
      in_pop_c[i]   = acc_in_valid[i] && acc_in_ready[i];
      out_push_c[i] = acc_out_valid[i] && acc_out_ready[i];
      out_pop_c[i]  = accel_read_enable && accel_can_read && (accel_id == ID_W'(i));
    end
  end

  // Next-state for pointers, counters, storage and the sticky error flag.
  always_comb begin
    in_mem_d  = in_mem_q;
    out_mem_d = out_mem_q;
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    in_cnt_d  = in_cnt_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q
              | (accel_write_enable && !accel_can_write)
              | (accel_read_enable && !accel_can_read);
    for (int i = 0; i < ACCEL_COUNT; i++) begin
      if (in_push_c[i]) begin
        in_mem_d[i][in_wr_q[i]] = accel_write_data;
        in_wr_d[i] = in_wr_q[i] + PTR_W'(1);
      end
      if (in_pop_c[i]) begin
        in_rd_d[i] = in_rd_q[i] + PTR_W'(1);
      end
      in_cnt_d[i] = in_cnt_q[i] + CNT_W'(in_push_c[i]) - CNT_W'(in_pop_c[i]);
      if (out_push_c[i]) begin
        out_mem_d[i][out_wr_q[i]] = acc_out_data[i*REG_WIDTH +: REG_WIDTH];
        out_wr_d[i] = out_wr_q[i] + PTR_W'(1);
      end
      if (out_pop_c[i]) begin
        out_rd_d[i] = out_rd_q[i] + PTR_W'(1);
      end
      out_cnt_d[i] = out_cnt_q[i] + CNT_W'(out_push_c[i]) - CNT_W'(out_pop_c[i]);
    end
  end

  // Control state: cleared asynchronously, which discards buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ACCEL_COUNT; i++) begin
        in_wr_q[i]   <= '0;
        in_rd_q[i]   <= '0;
        in_cnt_q[i]  <= '0;
        out_wr_q[i]  <= '0;
        out_rd_q[i]  <= '0;
        out_cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  // Data storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    out_mem_q <= out_mem_d;
  end

endmodule

// File: tb/tb_accel_hub.sv
// Testbench for accel_hub: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_accel_hub;

  localparam int AC = 4;
  localparam int W  = 16;
  localparam int D  = 2;

  logic            clk, rst;
  logic [3:0]      accel_id;
  logic            accel_can_write, accel_can_read;
  logic            accel_write_enable, accel_read_enable;
  logic [W-1:0]    accel_write_data, accel_read_data;
  logic [AC-1:0]   acc_in_valid, acc_in_ready, acc_out_valid, acc_out_ready;
  logic [AC*W-1:0] acc_in_data, acc_out_data;
  logic            err;

  accel_hub #(.ACCEL_COUNT(AC), .REG_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .accel_id(accel_id),
    .accel_can_write(accel_can_write), .accel_can_read(accel_can_read),
    .accel_write_enable(accel_write_enable), .accel_write_data(accel_write_data),
    .accel_read_enable(accel_read_enable), .accel_read_data(accel_read_data),
    .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready), .acc_in_data(acc_in_data),
    .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready), .acc_out_data(acc_out_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues per accelerator plus a sticky flag.
  logic [W-1:0] in_q  [AC][$];
  logic [W-1:0] out_q [AC][$];
  bit           m_err;
  bit           cur_cw, cur_cr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_cw(input logic [3:0] id);
    if (int'(id) >= AC) return 1'b0;
    return in_q[int'(id)].size() < D;
  endfunction

  function automatic bit m_cr(input logic [3:0] id);
    if (int'(id) >= AC) return 1'b0;
    return out_q[int'(id)].size() > 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < AC; i++) begin
      in_q[i].delete();
      out_q[i].delete();
    end
    m_err = 1'b0;
  endtask

  // Compare every observable output against the model's current state.
  task automatic cmp_all();
    logic [AC-1:0] ev, er;
    logic [W-1:0]  erd;
    cur_cw = m_cw(accel_id);
    cur_cr = m_cr(accel_id);
    erd = cur_cr ? out_q[int'(accel_id)][0] : '0;
    for (int i = 0; i < AC; i++) begin
      ev[i] = in_q[i].size() != 0;
      er[i] = out_q[i].size() < D;
    end
    check("can_write", 64'(accel_can_write), 64'(cur_cw));
    check("can_read", 64'(accel_can_read), 64'(cur_cr));
    check("read_data", 64'(accel_read_data), 64'(erd));
    check("in_valid", 64'(acc_in_valid), 64'(ev));
    check("out_ready", 64'(acc_out_ready), 64'(er));
    check("err", 64'(err), 64'(m_err));
    for (int i = 0; i < AC; i++)
      if (ev[i]) check("in_data", 64'(acc_in_data[i*W +: W]), 64'(in_q[i][0]));
  endtask

  // Apply one clock edge of traffic to the model.
  task automatic update();
    bit [AC-1:0] ipop, ipush, opush, opop;
    if (accel_write_enable && !cur_cw) m_err = 1'b1;
    if (accel_read_enable && !cur_cr) m_err = 1'b1;
    for (int i = 0; i < AC; i++) begin
      ipop[i]  = acc_in_ready[i] && in_q[i].size() > 0;
      ipush[i] = accel_write_enable && cur_cw && int'(accel_id) == i;
      opush[i] = acc_out_valid[i] && out_q[i].size() < D;
      opop[i]  = accel_read_enable && cur_cr && int'(accel_id) == i;
    end
    for (int i = 0; i < AC; i++) begin
      if (ipop[i])  void'(in_q[i].pop_front());
      if (ipush[i]) in_q[i].push_back(accel_write_data);
      if (opop[i])  void'(out_q[i].pop_front());
      if (opush[i]) out_q[i].push_back(acc_out_data[i*W +: W]);
    end
  endtask

  // One cycle: inputs already set at negedge; compare, clock, advance model.
  task automatic step();
    #1;
    cmp_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle();
    accel_write_enable = 1'b0;
    accel_read_enable  = 1'b0;
    acc_in_ready       = '0;
    acc_out_valid      = '0;
    accel_write_data   = '0;
    acc_out_data       = '0;
  endtask

  task automatic reset_lits();
    check("rst_in_valid", 64'(acc_in_valid), 64'h0);
    check("rst_out_ready", 64'(acc_out_ready), 64'hF);
    check("rst_can_write", 64'(accel_can_write), 64'h1);
    check("rst_can_read", 64'(accel_can_read), 64'h0);
    check("rst_read_data", 64'(accel_read_data), 64'h0);
    check("rst_err", 64'(err), 64'h0);
  endtask

  // Called at a negedge; holds reset across one rising edge.
  task automatic do_reset();
    idle();
    accel_id = 4'd0;
    rst = 1'b1;
    #1;
    model_clear();
    reset_lits();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    accel_id = '0;
    idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // Single write to accelerator 1 held off by ready.
    accel_id = 4'd1; accel_write_enable = 1'b1; accel_write_data = 16'h1234;
    step();
    accel_write_enable = 1'b0;
    #1;
    check("w1_valid", 64'(acc_in_valid), 64'h2);
    check("w1_slice", 64'(acc_in_data[1*W +: W]), 64'h1234);
    check("w1_can_write", 64'(accel_can_write), 64'h1);
    step();

    // Fill accelerator 2, overflow write, then drain in order.
    accel_id = 4'd2; accel_write_enable = 1'b1; accel_write_data = 16'h000A;
    step();
    accel_write_data = 16'h000B;
    step();
    accel_write_data = 16'h000C;
    #1;
    check("full_can_write", 64'(accel_can_write), 64'h0);
    step();
    accel_write_enable = 1'b0;
    #1;
    check("ovf_err", 64'(err), 64'h1);
    check("ovf_head", 64'(acc_in_data[2*W +: W]), 64'h000A);
    acc_in_ready = 4'b0100;
    step();
    #1;
    check("drain_head", 64'(acc_in_data[2*W +: W]), 64'h000B);
    step();
    acc_in_ready = '0;
    #1;
    check("drain_empty", 64'(acc_in_valid[2]), 64'h0);
    step();

    // Result from accelerator 3 read back by the CPU.
    do_reset();
    accel_id = 4'd3; acc_out_valid = 4'b1000; acc_out_data = 64'h55AA << 48;
    step();
    acc_out_valid = '0;
    #1;
    check("res_can_read", 64'(accel_can_read), 64'h1);
    check("res_data", 64'(accel_read_data), 64'h55AA);
    accel_read_enable = 1'b1;
    step();
    accel_read_enable = 1'b0;
    #1;
    check("res_empty_cr", 64'(accel_can_read), 64'h0);
    check("res_empty_rd", 64'(accel_read_data), 64'h0);
    step();

    // Simultaneous pop and push on result FIFO 0.
    accel_id = 4'd0; acc_out_valid = 4'b0001; acc_out_data = 64'h0011;
    step();
    accel_read_enable = 1'b1; acc_out_valid = 4'b0001; acc_out_data = 64'h0042;
    #1;
    check("sim_old", 64'(accel_read_data), 64'h0011);
    step();
    accel_read_enable = 1'b0; acc_out_valid = '0;
    #1;
    check("sim_can_read", 64'(accel_can_read), 64'h1);
    check("sim_new", 64'(accel_read_data), 64'h0042);
    accel_read_enable = 1'b1;
    step();
    accel_read_enable = 1'b0;
    #1;
    check("sim_drained", 64'(accel_can_read), 64'h0);
    check("pre_oor_err", 64'(err), 64'h0);

    // Out-of-range id write is refused and flagged.
    accel_id = 4'd7; accel_write_enable = 1'b1; accel_write_data = 16'hBEEF;
    #1;
    check("oor_can_write", 64'(accel_can_write), 64'h0);
    step();
    accel_write_enable = 1'b0; accel_id = 4'd0;
    #1;
    check("oor_err", 64'(err), 64'h1);
    check("oor_valid", 64'(acc_in_valid), 64'h0);
    step();

    // Asynchronous reset between edges discards buffered words.
    do_reset();
    accel_write_enable = 1'b1; accel_write_data = 16'h1111;
    step();
    accel_write_data = 16'h2222;
    step();
    accel_write_enable = 1'b0;
    #1;
    check("buf_valid", 64'(acc_in_valid), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    reset_lits();
    #1;
    rst = 1'b0;
    @(negedge clk);
    acc_in_ready = 4'hF;
    step();
    step();
    acc_in_ready = '0;
    accel_write_enable = 1'b1; accel_write_data = 16'h3333;
    step();
    accel_write_enable = 1'b0;
    #1;
    check("post_rst_valid", 64'(acc_in_valid), 64'h1);
    check("post_rst_head", 64'(acc_in_data[0 +: W]), 64'h3333);
    step();

    // Randomized traffic; violations are kept rare so err stays informative.
    for (int n = 0; n < 2400; n++) begin
      if (n % 400 == 0) do_reset();
      if ($urandom_range(0, 9) == 0) accel_id = 4'($urandom_range(AC, 15));
      else accel_id = 4'($urandom_range(0, AC - 1));
      accel_write_enable = ($urandom_range(0, 1) == 1) &&
                           (m_cw(accel_id) || $urandom_range(0, 60) == 0);
      accel_read_enable  = ($urandom_range(0, 1) == 1) &&
                           (m_cr(accel_id) || $urandom_range(0, 60) == 0);
      accel_write_data = W'($urandom);
      acc_in_ready  = AC'($urandom);
      acc_out_valid = AC'($urandom);
      acc_out_data  = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
